// File: rtl/serial_parallel_argmax_stream.sv
// Streaming argmax over one frame of up to NUM_INPUTS values, LANES values per beat.
// Each accepted beat is reduced across its lanes in one cycle and folded into a
// running max/argmax. The frame result is held on a valid/ready output until taken.
//
// Handshake: an input beat transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. in_ready is high
// only while accumulating and out_valid only while holding a result, so a frame's
// result must be taken before the next frame's first beat can be accepted.
module serial_parallel_argmax_stream #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 16,
  parameter int NUM_INPUTS  = 256,
  parameter int INDEX_WIDTH = $clog2(NUM_INPUTS),
  parameter int SIGNED      = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LANES*WIDTH-1:0]                   in_data,
  input  logic                                     in_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WIDTH-1:0]                         max,
  output logic [INDEX_WIDTH-1:0]                   argmax,
  output logic [$clog2(NUM_INPUTS/LANES+1)-1:0]    beat_count
);

  localparam int NUM_BEATS = NUM_INPUTS / LANES;
  localparam int BCW       = $clog2(NUM_BEATS + 1);
  localparam int LANE_W    = $clog2(LANES);
  // Smallest representable value: the starting point of every frame's running max.
  localparam logic [WIDTH-1:0] MIN_VAL =
    (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]       run_max_q, run_max_d;
  logic [INDEX_WIDTH-1:0] run_idx_q, run_idx_d;
  logic [WIDTH-1:0]       max_q, max_d;
  logic [INDEX_WIDTH-1:0] argmax_q, argmax_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d;

  logic [WIDTH-1:0]       bmax;
  logic [LANE_W-1:0]      blane;
  logic                   accept;
  logic [INDEX_WIDTH-1:0] beat_idx;
  logic [WIDTH-1:0]       fold_max;
  logic [INDEX_WIDTH-1:0] fold_idx;

  // Strict greater-than in the configured number format.
  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Lane reduction: strict compare means the lowest lane keeps a tie.
  always_comb begin
    bmax  = in_data[WIDTH-1:0];
    blane = '0;
    for (int k = 1; k < LANES; k++) begin
      if (gt(in_data[k*WIDTH +: WIDTH], bmax)) begin
        bmax  = in_data[k*WIDTH +: WIDTH];
        blane = LANE_W'(k);
      end
    end
  end

  // Next-state: fold accepted beats, close the frame, release on consume.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    max_d     = max_q;
    argmax_d  = argmax_q;
    bcnt_d    = bcnt_q;

    accept   = in_valid && (state_q == ACCUM);
    beat_idx = (INDEX_WIDTH'(cnt_q) << LANE_W) + INDEX_WIDTH'(blane);
    // Earlier beats keep ties, so only a strictly larger beat winner replaces them.
    fold_max = gt(bmax, run_max_q) ? bmax     : run_max_q;
    fold_idx = gt(bmax, run_max_q) ? beat_idx : run_idx_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d     = cnt_q + BCW'(1);
          run_max_d = fold_max;
          run_idx_d = fold_idx;
          // The last slot of a full frame closes it even without in_last.
          if (in_last || (cnt_q == BCW'(NUM_BEATS - 1))) begin
            state_d  = DONE;
            max_d    = fold_max;
            argmax_d = fold_idx;
            bcnt_d   = cnt_q + BCW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d   = ACCUM;
          cnt_d     = '0;
          run_max_d = MIN_VAL;
          run_idx_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      run_max_q <= MIN_VAL;
      run_idx_q <= '0;
      max_q     <= MIN_VAL;
      argmax_q  <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      max_q     <= max_d;
      argmax_q  <= argmax_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign max        = max_q;
  assign argmax     = argmax_q;
  assign beat_count = bcnt_q;

endmodule
